// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default frame/baud parameters.
// Used by uart_rx and the future uart_tx.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } uart_state_e;

    localparam int DBIT_DEF     = 8;
    localparam int SB_TICK_DEF  = 16;
    localparam int BAUD_DIV_DEF = 163;

endpackage

// File: rtl/baud_rate_gen.sv
// Free-running oversampling tick generator: one-cycle o_tick every BAUD_DIV clocks.
// Shared between uart_rx and the future uart_tx.
module baud_rate_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver (8N1 default).
// Define UART_RX_PARITY_EN to expect an even-parity bit and add o_parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT     = DBIT_DEF,
    parameter int SB_TICK  = SB_TICK_DEF,
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_rx,
    output logic            o_rx_done_tick,
    output logic [DBIT-1:0] o_rx_data,
`ifdef UART_RX_PARITY_EN
    output logic            o_parity_err,
`endif
    output logic            o_frame_err
);

    localparam int NW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int BW = $clog2(DBIT);
    localparam logic [NW-1:0] N_MID  = NW'(7);
    localparam logic [NW-1:0] N_BIT  = NW'(15);
    localparam logic [NW-1:0] N_STOP = NW'(SB_TICK - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);
`ifdef UART_RX_PARITY_EN
    localparam uart_state_e AFTER_DATA = PARITY;
`else
    localparam uart_state_e AFTER_DATA = STOP;
`endif

    logic s_tick;
    logic rx_meta_q, rx_s_q;
    logic rx_s;

    uart_state_e     state_q, state_d;
    logic [NW-1:0]   n_q, n_d;
    logic [BW-1:0]   b_q, b_d;
    logic [DBIT-1:0] sh_q, sh_d;
    logic [DBIT-1:0] data_q, data_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    baud_rate_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .o_tick(s_tick)
    );

    assign rx_s = rx_s_q;

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        b_d     = b_q;
        sh_d    = sh_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    n_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (n_q == N_MID) begin
                        n_d     = '0;
                        b_d     = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (n_q == N_BIT) begin
                        n_d  = '0;
                        sh_d = {rx_s, sh_q[DBIT-1:1]};
                        if (b_q == B_LAST) state_d = AFTER_DATA;
                        else               b_d = b_q + 1'b1;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (n_q == N_BIT) begin
                        n_d     = '0;
                        par_d   = rx_s;
                        state_d = STOP;
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (n_q == N_STOP) begin
                        if (rx_s) begin
                            data_d  = sh_q;
                            done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_d  = par_q ^ (^sh_q);
`endif
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_IDLE;
                        end
                    end else begin
                        n_d = n_q + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            n_q       <= '0;
            b_q       <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            n_q       <= n_d;
            b_q       <= b_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign o_rx_done_tick = done_q;
    assign o_frame_err    = ferr_q;
    assign o_rx_data      = data_q;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err   = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expectations, a monitor
// pops and compares on every strobe.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BD = 10;
    localparam int T  = 16 * BD;
`ifdef UART_RX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       done, ferr, perr;
    logic [7:0] data;

    typedef struct packed {
        logic       is_ferr;
        logic [7:0] data;
        logic       perr;
    } exp_t;

    exp_t   q[$];
    longint strobe_cyc[$];
    longint cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;

    uart_rx #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(BD)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx          (rx),
        .o_rx_done_tick(done),
        .o_rx_data     (data),
`ifdef UART_RX_PARITY_EN
        .o_parity_err  (perr),
`endif
        .o_frame_err   (ferr)
    );

`ifndef UART_RX_PARITY_EN
    assign perr = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done || ferr) begin
            chk("strobe_exclusive", {31'd0, done & ferr}, 0);
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe: done=%0b ferr=%0b data=%0h",
                         done, ferr, data);
            end else begin
                e = q.pop_front();
                chk("strobe_kind", {31'd0, ferr}, {31'd0, e.is_ferr});
                chk("rx_data", {24'd0, data}, {24'd0, e.data});
`ifdef UART_RX_PARITY_EN
                if (done) chk("parity_err", {31'd0, perr}, {31'd0, e.perr});
`endif
                if (done) strobe_cyc.push_back(cyc);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v, input bit rst_mid);
        rx = v;
        if (rst_mid) begin
            wait_cyc(T / 2);
            rst = 1'b0;
            wait_cyc(T - T / 2);
        end else begin
            wait_cyc(T);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic par_flip, input int rst_bit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], i == rst_bit);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip, 1'b0);
`endif
        send_bit(stop_v, 1'b0);
        if (rst_bit >= 0) rst = 1'b1;
    endtask

    task automatic push_data(input logic [7:0] d, input logic pe);
        exp_t e;
        e.is_ferr = 1'b0;
        e.data    = d;
        e.perr    = pe;
        q.push_back(e);
    endtask

    task automatic push_ferr(input logic [7:0] held);
        exp_t e;
        e.is_ferr = 1'b1;
        e.data    = held;
        e.perr    = 1'b0;
        q.push_back(e);
    endtask

    initial begin
        longint d1, d2;
        int     guard;

        rst = 1'b0;
        rx  = 1'b1;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(1);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_ferr", {31'd0, ferr}, 0);
        chk("rst_data", {24'd0, data}, 0);
        chk("rst_state", {29'd0, dut.state_q}, {29'd0, IDLE});

        push_data(8'h02, 1'b0);
        push_data(8'h01, 1'b0);
        push_data(8'h20, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0, -1);
        send_frame(8'h01, 1'b1, 1'b0, -1);
        send_frame(8'h20, 1'b1, 1'b0, -1);
        rx = 1'b1;
        wait_cyc(2 * T);
        chk("b2b_count", strobe_cyc.size(), 3);
        if (strobe_cyc.size() >= 3) begin
            d1 = strobe_cyc[1] - strobe_cyc[0];
            d2 = strobe_cyc[2] - strobe_cyc[1];
            chk("spacing_1", {31'd0, (d1 >= FB * T - 2 * BD) &&
                                     (d1 <= FB * T + 2 * BD)}, 1);
            chk("spacing_2", {31'd0, (d2 >= FB * T - 2 * BD) &&
                                     (d2 <= FB * T + 2 * BD)}, 1);
        end

        rx = 1'b0;
        wait_cyc(3 * BD);
        rx = 1'b1;
        wait_cyc(2 * T);
        chk("glitch_state", {29'd0, dut.state_q}, {29'd0, IDLE});
        push_data(8'h07, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, -1);
        wait_cyc(2 * T);

        push_ferr(8'h07);
        send_frame(8'h05, 1'b0, 1'b0, -1);
        rx = 1'b0;
        wait_cyc(5 * T);
        chk("break_state", {29'd0, dut.state_q}, {29'd0, WAIT_IDLE});
        rx = 1'b1;
        wait_cyc(T);
        chk("break_release", {29'd0, dut.state_q}, {29'd0, IDLE});

        send_frame(8'h24, 1'b1, 1'b0, 4);
        wait_cyc(2 * T);
        chk("abort_state", {29'd0, dut.state_q}, {29'd0, IDLE});
        chk("abort_data", {24'd0, data}, 0);
        push_data(8'h24, 1'b0);
        send_frame(8'h24, 1'b1, 1'b0, -1);
        wait_cyc(2 * T);

`ifdef UART_RX_PARITY_EN
        push_data(8'h07, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1, -1);
        push_data(8'h07, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, -1);
        wait_cyc(2 * T);
`endif

        guard = 0;
        while (q.size() != 0 && guard < 20 * T) begin
            wait_cyc(1);
            guard++;
        end
        chk("drain", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
